pipe_stall_ctrl: RTL and testbench
==================================

# pipe_stall_ctrl

- Central stall controller: it drives the 6-bit `stall` vector that every pipeline register consumes.
  - The pipeline registers are PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- It merges stall requests from ID, EX and MEM, and adds a sequencer that holds EX for a programmed number of cycles during multi-cycle operations (multiply/divide).
- It also keeps a saturating stall-cycle performance counter.
- It sits beside the pipeline. Its `stall` output reaches every stage register in the same cycle it is produced.

## Interface
Parameters:
- `MC_CNT_W`, default 5: width of the multi-cycle length field.
- `PERF_W`, default 32: width of the stall performance counter.

Ports:
- `clk` in 1: the single clock. Every register updates on its rising edge.
- `rst` in 1: reset. Synchronous, active-high (`RstEnable` = 1'b1), sampled on the rising edge of `clk`.
- `stallreq_from_id` in 1: load-use hazard request from ID.
- `stallreq_from_ex` in 1: generic EX hold request, combinational from EX.
- `stallreq_from_mem` in 1: memory bus wait from MEM.
- `mc_start` in 1: EX is beginning a multi-cycle op. Sampled only in state IDLE.
- `mc_cycles` in `MC_CNT_W`: number of cycles EX is held. A value of 0 is treated as 1.
- `mc_busy` out 1: the sequencer is in state BUSY.
- `mc_done` out 1: one-cycle pulse; the multi-cycle result is valid this cycle.
- `stall` out 6: bit 0 PC, bit 1 IF/ID, bit 2 ID/EX, bit 3 EX/MEM, bit 4 MEM/WB, bit 5 WB. `Stop` = 1.
- `stall_cycles` out `PERF_W`: number of cycles with `stall[0]` = 1. Saturates at all-ones.

## Operation
- `stall` is combinational in the current cycle from the request inputs and the sequencer state.
  - Stage registers apply it on the next edge.
- Stall levels, deepest source wins:
  - MEM request: `stall` = 6'b011111.
  - EX hold: `stall` = 6'b001111. EX hold means `stallreq_from_ex`, or `mc_start` while in IDLE, or state BUSY.
  - ID request: `stall` = 6'b000111.
  - No request: `stall` = 6'b000000.
- An ID-level stall makes ID/EX see `stall[2]` = Stop with `stall[3]` = NoStop, so ID/EX inserts a bubble. This behaviour is required.
- While `rst` = 1, `stall` is forced to 6'b000000.
- Sequencer FSM, with a down-counter `cnt` of width `MC_CNT_W`:
  - IDLE, on `mc_start`: let N = max(`mc_cycles`, 1).
    - If N = 1, go to DONE.
    - Otherwise set `cnt` ← N−1 and go to BUSY.
  - BUSY: `cnt` decrements each cycle. When `cnt` = 1, go to DONE.
  - DONE: `mc_done` = 1, no EX hold from the sequencer. Return to IDLE.
- EX-level stall cycles per op = N: the start cycle plus N−1 BUSY cycles. The EX instruction advances on the DONE cycle.
- `mc_start` is ignored in BUSY and DONE. No queuing.
- A MEM stall during BUSY or DONE:
  - It does not freeze `cnt`; the sequencer counts cycles, not advances.
  - `mc_done` still pulses exactly once.
  - EX is held by MEM beyond DONE, and must latch its result on `mc_done`.
- Perf counter: increments when `stall[0]` = 1. It stays at all-ones once reached.

## Timing
- Reset values: state IDLE, `cnt` 0, `mc_busy` 0, `mc_done` 0, `stall_cycles` 0, `stall` 6'b000000.
- Reset taking effect mid-BUSY aborts the op. The next cycle is IDLE with no `mc_done`.
- Latency from request input to `stall`: 0 cycles (combinational).
- Latency from `mc_start` to `mc_done`: N cycles. `mc_busy` is registered and is high for N−1 cycles.
- `mc_done` is registered and is high for exactly one cycle per accepted start.
- The sequencer can accept a new `mc_start` in the cycle after DONE.

## Structure
- The stall masks (6'b000111, 6'b001111, 6'b011111), `Stop`/`NoStop`, `RstEnable` and the FSM state encodings go in shared `defines.v`.
- FSM state encoding is 2 bits.
- Single module, with one optional sub-module `sat_counter` for the perf counter. It is reusable by other perf counters.

## Test plan
- Reset: hold `rst` = 1 for 2 cycles with all requests high → `stall` = 0, `mc_done` = 0, `stall_cycles` = 0.
- Priority: drive ID+EX+MEM requests together → `stall` = 6'b011111. Drop MEM → 6'b001111. Drop EX → 6'b000111. Check ID/EX bubble behaviour.
- Multi-cycle: `mc_start` with `mc_cycles` = 4 → `stall` = 6'b001111 for 4 cycles, `mc_busy` high for 3, `mc_done` in the 5th cycle.
- Edge lengths:
  - `mc_cycles` = 0 → 1 stall cycle, `mc_done` in the next cycle.
  - `mc_start` held high through BUSY → only one `mc_done`.
- Overlap: `stallreq_from_mem` high across DONE → `mc_done` fires once and `stall` = 6'b011111 on that cycle. Abort: `rst` during BUSY → IDLE, no `mc_done`.
- Perf saturation with `PERF_W` = 4: 20 stalled cycles → `stall_cycles` = 15 and holds.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared constants for the pipeline stall controller: stall masks,
// stop/no-stop levels, reset polarity and sequencer state encodings.
package pipe_stall_ctrl_pkg;

    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;
    localparam logic RST_ENABLE = 1'b1;

    localparam int unsigned STALL_W = 6;

    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_BUSY = 2'b01,
        MC_DONE = 2'b10
    } mc_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_sat_counter.sv
// Reusable saturating event counter: counts cycles with inc high and
// sticks at all-ones once reached.
module sat_counter
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, hold at all-ones.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller: merges ID/EX/MEM stall requests,
// sequences multi-cycle EX operations and counts stalled cycles.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int unsigned MC_CNT_W = 5,
    parameter int unsigned PERF_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stallreq_from_id,
    input  logic                stallreq_from_ex,
    input  logic                stallreq_from_mem,
    input  logic                mc_start,
    input  logic [MC_CNT_W-1:0] mc_cycles,
    output logic                mc_busy,
    output logic                mc_done,
    output logic [STALL_W-1:0]  stall,
    output logic [PERF_W-1:0]   stall_cycles
);

    mc_state_t           state, state_nxt;
    logic [MC_CNT_W-1:0] cnt, cnt_nxt;
    logic                ex_hold;

    // Sequencer state and down-counter register.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Sequencer next state: N = max(mc_cycles, 1); the start cycle is the
    // first held cycle, so BUSY lasts N-1 cycles. MEM stalls do not freeze it.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            MC_IDLE: begin
                if (mc_start) begin
                    if (mc_cycles <= MC_CNT_W'(1)) begin
                        state_nxt = MC_DONE;
                    end else begin
                        cnt_nxt   = mc_cycles - MC_CNT_W'(1);
                        state_nxt = MC_BUSY;
                    end
                end
            end
            MC_BUSY: begin
                cnt_nxt = cnt - MC_CNT_W'(1);
                if (cnt == MC_CNT_W'(1)) begin
                    state_nxt = MC_DONE;
                end
            end
            MC_DONE: begin
                state_nxt = MC_IDLE;
            end
            default: begin
                state_nxt = MC_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign mc_busy = (state == MC_BUSY);
    assign mc_done = (state == MC_DONE);

    // Stall vector: deepest requesting stage wins; an ID-level stall leaves
    // ID/EX stopped with EX/MEM running, which inserts the bubble.
    always_comb begin
        ex_hold = stallreq_from_ex || (state == MC_BUSY) ||
                  ((state == MC_IDLE) && mc_start);
        if (rst == RST_ENABLE) begin
            stall = STALL_NONE;
        end else if (stallreq_from_mem) begin
            stall = STALL_MEM;
        end else if (ex_hold) begin
            stall = STALL_EX;
        end else if (stallreq_from_id) begin
            stall = STALL_ID;
        end else begin
            stall = STALL_NONE;
        end
    end

    sat_counter #(
        .W(PERF_W)
    ) u_perf (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall[0]),
        .count(stall_cycles)
    );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios followed by
// random stimulus, compared against a cycle-level behavioural model.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic        mc_start;
    logic [4:0]  mc_cycles;
    logic        mc_busy, mc_done;
    logic [5:0]  stall;
    logic [31:0] stall_cycles;
    logic        mc_busy_s, mc_done_s;
    logic [5:0]  stall_s;
    logic [3:0]  stall_cycles_s;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    // Model state: remaining BUSY cycles of the current op and done flag.
    int          hold_left = 0;
    bit          done_now  = 1'b0;
    logic [31:0] m_perf32  = '0;
    logic [3:0]  m_perf4   = '0;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.MC_CNT_W(5), .PERF_W(32)) dut (
        .clk(clk), .rst(rst),
        .stallreq_from_id(stallreq_from_id), .stallreq_from_ex(stallreq_from_ex),
        .stallreq_from_mem(stallreq_from_mem), .mc_start(mc_start), .mc_cycles(mc_cycles),
        .mc_busy(mc_busy), .mc_done(mc_done), .stall(stall), .stall_cycles(stall_cycles)
    );

    pipe_stall_ctrl #(.MC_CNT_W(5), .PERF_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .stallreq_from_id(stallreq_from_id), .stallreq_from_ex(stallreq_from_ex),
        .stallreq_from_mem(stallreq_from_mem), .mc_start(mc_start), .mc_cycles(mc_cycles),
        .mc_busy(mc_busy_s), .mc_done(mc_done_s), .stall(stall_s), .stall_cycles(stall_cycles_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs against the model, then
    // advance the model across the clock edge.
    task automatic step(input logic r, input logic id, input logic ex, input logic mem,
                        input logic st, input logic [4:0] cyc);
        bit         idle;
        bit         exh;
        logic [5:0] es;
        int         n;
        rst = r; stallreq_from_id = id; stallreq_from_ex = ex;
        stallreq_from_mem = mem; mc_start = st; mc_cycles = cyc;
        #1;
        idle = (hold_left == 0) && !done_now;
        exh  = ex || (idle && st) || (hold_left > 0);
        if (r)        es = 6'b000000;
        else if (mem) es = 6'b011111;
        else if (exh) es = 6'b001111;
        else if (id)  es = 6'b000111;
        else          es = 6'b000000;
        chk("stall", 32'(stall), 32'(es));
        chk("mc_busy", 32'(mc_busy), 32'(hold_left > 0));
        chk("mc_done", 32'(mc_done), 32'(done_now));
        chk("stall_cycles", stall_cycles, m_perf32);
        chk("stall_cycles_sat", 32'(stall_cycles_s), 32'(m_perf4));
        if (mc_done) done_seen++;
        @(posedge clk);
        if (r) begin
            hold_left = 0; done_now = 1'b0; m_perf32 = '0; m_perf4 = '0;
        end else begin
            if (es[0]) begin
                if (m_perf32 != 32'hFFFF_FFFF) m_perf32 = m_perf32 + 1;
                if (m_perf4 < 4'd15) m_perf4 = m_perf4 + 1;
            end
            if (idle && st) begin
                n = (cyc == 0) ? 1 : int'(cyc);
                hold_left = n - 1;
                done_now  = (n == 1);
            end else if (hold_left > 0) begin
                hold_left--;
                done_now = (hold_left == 0);
            end else begin
                done_now = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stallreq_from_id = 1'b1; stallreq_from_ex = 1'b1;
        stallreq_from_mem = 1'b1; mc_start = 1'b1; mc_cycles = 5'd4;
        @(posedge clk);
        @(negedge clk);

        // Reset held with every request high.
        step(1, 1, 1, 1, 1, 5'd4);
        step(1, 1, 1, 1, 1, 5'd4);
        chk("reset_stall", 32'(stall), 32'h0);

        // Priority ladder and ID/EX bubble.
        step(0, 1, 1, 1, 0, 5'd0);
        step(0, 1, 1, 0, 0, 5'd0);
        rst = 1'b0; stallreq_from_id = 1'b1; stallreq_from_ex = 1'b0;
        stallreq_from_mem = 1'b0; mc_start = 1'b0;
        #1;
        chk("idex_bubble", 32'({stall[3], stall[2]}), 32'b01);
        step(0, 1, 0, 0, 0, 5'd0);
        step(0, 0, 0, 0, 0, 5'd0);

        // Four-cycle op.
        done_seen = 0;
        step(0, 0, 0, 0, 1, 5'd4);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 5'd0);
        chk("mc4_done_count", 32'(done_seen), 32'd1);

        // Zero length behaves as one.
        done_seen = 0;
        step(0, 0, 0, 0, 1, 5'd0);
        step(0, 0, 0, 0, 0, 5'd0);
        step(0, 0, 0, 0, 0, 5'd0);
        chk("mc0_done_count", 32'(done_seen), 32'd1);

        // Start held through BUSY and DONE: one completion.
        done_seen = 0;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 5'd3);
        step(0, 0, 0, 0, 0, 5'd0);
        chk("held_start_done_count", 32'(done_seen), 32'd1);

        // MEM stall across the whole op including DONE.
        done_seen = 0;
        step(0, 0, 0, 1, 1, 5'd3);
        step(0, 0, 0, 1, 0, 5'd0);
        step(0, 0, 0, 1, 0, 5'd0);
        #1;
        chk("mem_over_done_pulse", 32'(mc_done), 32'd1);
        chk("mem_over_done_stall", 32'(stall), 32'h1F);
        step(0, 0, 0, 1, 0, 5'd0);
        step(0, 0, 0, 0, 0, 5'd0);
        chk("mem_overlap_done_count", 32'(done_seen), 32'd1);

        // Reset mid-BUSY aborts without a completion.
        done_seen = 0;
        step(0, 0, 0, 0, 1, 5'd6);
        step(0, 0, 0, 0, 0, 5'd0);
        step(1, 0, 0, 0, 0, 5'd0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 5'd0);
        chk("abort_done_count", 32'(done_seen), 32'd0);

        // Perf saturation on the 4-bit counter.
        step(1, 0, 0, 0, 0, 5'd0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, 5'd0);
        chk("perf4_saturated", 32'(stall_cycles_s), 32'd15);
        step(0, 1, 0, 0, 0, 5'd0);
        chk("perf4_holds", 32'(stall_cycles_s), 32'd15);
        chk("perf32_count", stall_cycles, 32'd21);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 9)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
